// File: rtl/btree_mux_pipe.sv
// btree_mux_pipe: pipelined binary-tree mux; highest-index set flag wins, registered every REG_EVERY levels.
// Define BTREE_PIPE_INDEX_EN to also produce the winning input index on index_out.
module btree_mux_pipe #(
   parameter int INPUT_COUNT = 64,
   parameter int INPUT_WIDTH = 6,
   parameter int REG_EVERY   = 2
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               valid_in,
   input  logic                               stall,
   input  logic                               flush,
   input  logic [INPUT_COUNT-1:0]             flags_in,
   input  logic [INPUT_COUNT*INPUT_WIDTH-1:0] data_in,
   output logic                               valid_out,
   output logic                               flag_out,
   output logic [INPUT_WIDTH-1:0]             data_out
`ifdef BTREE_PIPE_INDEX_EN
   ,
   output logic [$clog2(INPUT_COUNT)-1:0]     index_out
`endif
);
   localparam int N       = INPUT_COUNT;
   localparam int LEVELS  = $clog2(INPUT_COUNT);
   localparam int NSTAGES = (LEVELS + REG_EVERY - 1) / REG_EVERY;

   logic [NSTAGES-1:0] r_v;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)
         r_v <= '0;
      else if (flush)
         r_v <= '0;
      else if (!stall) begin
         r_v[0] <= valid_in;
         for (int s = 1; s < NSTAGES; s++) r_v[s] <= r_v[s-1];
      end

   // Heap-numbered nodes: node 1 is the root, node k combines children 2k (left) and 2k+1 (right).
   for (genvar k = 1; k < N; k++) begin : g_node
      localparam int L = LEVELS - $clog2(k + 1) + 1;
      logic                   w_lf, w_rf, w_nf, w_of;
      logic [INPUT_WIDTH-1:0] w_ld, w_rd, w_nd, w_od;
      if (2 * k >= N) begin : g_leaf
         assign w_lf = flags_in[2*k-N];
         assign w_rf = flags_in[2*k+1-N];
         assign w_ld = data_in[(2*k-N)*INPUT_WIDTH +: INPUT_WIDTH];
         assign w_rd = data_in[(2*k+1-N)*INPUT_WIDTH +: INPUT_WIDTH];
      end else begin : g_inner
         assign w_lf = g_node[2*k].w_of;
         assign w_rf = g_node[2*k+1].w_of;
         assign w_ld = g_node[2*k].w_od;
         assign w_rd = g_node[2*k+1].w_od;
      end
      assign w_nf = w_lf | w_rf;
      assign w_nd = w_rf ? w_rd : (w_lf ? w_ld : '0);
      if (L % REG_EVERY == 0 || L == LEVELS) begin : g_reg
         logic                   r_f;
         logic [INPUT_WIDTH-1:0] r_d;
         always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) begin
               r_f <= 1'b0;
               r_d <= '0;
            end else if (!stall) begin
               r_f <= w_nf;
               r_d <= w_nd;
            end
         assign w_of = r_f;
         assign w_od = r_d;
      end else begin : g_comb
         assign w_of = w_nf;
         assign w_od = w_nd;
      end
`ifdef BTREE_PIPE_INDEX_EN
      logic [LEVELS-1:0] w_li, w_ri, w_ni, w_oi;
      if (2 * k >= N) begin : g_ileaf
         assign w_li = '0;
         assign w_ri = '0;
      end else begin : g_iinner
         assign w_li = g_node[2*k].w_oi;
         assign w_ri = g_node[2*k+1].w_oi;
      end
      // A node at level L owns index bit L-1: set when the right child wins.
      assign w_ni = w_rf ? (w_ri | (LEVELS'(1) << (L - 1))) : (w_lf ? w_li : '0);
      if (L % REG_EVERY == 0 || L == LEVELS) begin : g_ireg
         logic [LEVELS-1:0] r_i;
         always_ff @(posedge clk or negedge rst_n)
            if (!rst_n)
               r_i <= '0;
            else if (!stall)
               r_i <= w_ni;
         assign w_oi = r_i;
      end else begin : g_icomb
         assign w_oi = w_ni;
      end
`endif
   end

   assign valid_out = r_v[NSTAGES-1];
   assign flag_out  = g_node[1].w_of;
   assign data_out  = g_node[1].w_od;
`ifdef BTREE_PIPE_INDEX_EN
   assign index_out = g_node[1].w_oi;
`endif
endmodule

// File: tb/tb_btree_mux_pipe.sv
// tb_btree_mux_pipe: scoreboard bench for btree_mux_pipe at 64/2, plus 2-input and 1024-input latency checks.
module tb_btree_mux_pipe;
   typedef struct {
      int         due;
      logic       f;
      logic [5:0] d;
      logic [5:0] i;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic         m_v, m_s, m_fl, m_vo, m_fo;
   logic [63:0]  m_f;
   logic [383:0] m_d;
   logic [5:0]   m_do;
   logic         s_v, s_vo, s_fo;
   logic [1:0]   s_f;
   logic [7:0]   s_d;
   logic [3:0]   s_do;
   logic           b_v, b_vo, b_fo;
   logic [1023:0]  b_f;
   logic [10239:0] b_d;
   logic [9:0]     b_do;
`ifdef BTREE_PIPE_INDEX_EN
   logic [5:0] m_io;
   logic [0:0] s_io;
   logic [9:0] b_io;
`endif

   btree_mux_pipe #(.INPUT_COUNT(64), .INPUT_WIDTH(6), .REG_EVERY(2)) u_main (
      .clk(clk), .rst_n(rst_n), .valid_in(m_v), .stall(m_s), .flush(m_fl),
      .flags_in(m_f), .data_in(m_d), .valid_out(m_vo), .flag_out(m_fo), .data_out(m_do)
`ifdef BTREE_PIPE_INDEX_EN
      , .index_out(m_io)
`endif
   );
   btree_mux_pipe #(.INPUT_COUNT(2), .INPUT_WIDTH(4), .REG_EVERY(1)) u_small (
      .clk(clk), .rst_n(rst_n), .valid_in(s_v), .stall(1'b0), .flush(1'b0),
      .flags_in(s_f), .data_in(s_d), .valid_out(s_vo), .flag_out(s_fo), .data_out(s_do)
`ifdef BTREE_PIPE_INDEX_EN
      , .index_out(s_io)
`endif
   );
   btree_mux_pipe #(.INPUT_COUNT(1024), .INPUT_WIDTH(10), .REG_EVERY(3)) u_big (
      .clk(clk), .rst_n(rst_n), .valid_in(b_v), .stall(1'b0), .flush(1'b0),
      .flags_in(b_f), .data_in(b_d), .valid_out(b_vo), .flag_out(b_fo), .data_out(b_do)
`ifdef BTREE_PIPE_INDEX_EN
      , .index_out(b_io)
`endif
   );

   int   n_cmp = 0;
   int   n_bad = 0;
   int   act = 0;
   logic l_stall = 1'b0;
   logic l_flush = 1'b0;
   logic hold_v = 1'b0;
   exp_t hold;
   exp_t q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [63:0] f, input logic [383:0] d);
      exp_t e;
      e.due = 0;
      e.f = 1'b0;
      e.d = '0;
      e.i = '0;
      for (int k = 0; k < 64; k++)
         if (f[k]) begin
            e.f = 1'b1;
            e.d = d[k*6 +: 6];
            e.i = 6'(k);
         end
      return e;
   endfunction

   task automatic drive(input logic v, input logic s, input logic fl, input logic [63:0] f, input bit keep = 1);
      exp_t e;
      @(posedge clk);
      #1;
      m_v = v;
      m_s = s;
      m_fl = fl;
      m_f = f;
      if (v && !s && !fl && keep) begin
         e = model(f, m_d);
         e.due = act + 3;
         q.push_back(e);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 1'b0, 1'b0, '0);
   endtask

   task automatic small_chk(input logic [1:0] f, input logic fe, input logic [3:0] de, input logic ie);
      @(posedge clk);
      #1;
      s_v = 1'b1;
      s_f = f;
      @(posedge clk);
      #1;
      chk("s_valid", s_vo, 1);
      chk("s_flag", s_fo, fe);
      chk("s_data", s_do, de);
`ifdef BTREE_PIPE_INDEX_EN
      chk("s_index", s_io, ie);
`else
      if (ie === 1'bx) $display("unreachable");
`endif
      s_v = 1'b0;
      @(posedge clk);
      #1;
      chk("s_idle", s_vo, 0);
   endtask

   task automatic big_chk(input logic [1023:0] f, input logic fe, input logic [9:0] de);
      @(posedge clk);
      #1;
      b_v = 1'b1;
      b_f = f;
      @(posedge clk);
      #1;
      b_v = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("b_early", b_vo, 0);
      @(posedge clk);
      #1;
      chk("b_valid", b_vo, 1);
      chk("b_flag", b_fo, fe);
      chk("b_data", b_do, de);
`ifdef BTREE_PIPE_INDEX_EN
      chk("b_index", b_io, de);
`endif
   endtask

   always @(posedge clk) begin
      l_stall = m_s;
      l_flush = m_fl;
      if (rst_n && !m_s) act++;
   end

   // Each cycle after an unstalled edge, the head of the queue is due exactly when act reaches its due count.
   always @(negedge clk)
      if (rst_n) begin
         logic ev;
         ev = l_flush ? 1'b0 : (l_stall ? hold_v : (q.size() > 0 && q[0].due == act));
         chk("m_valid", m_vo, ev);
         if (ev) begin
            if (!l_stall) hold = q.pop_front();
            chk("m_flag", m_fo, hold.f);
            chk("m_data", m_do, hold.d);
`ifdef BTREE_PIPE_INDEX_EN
            chk("m_index", m_io, hold.i);
`endif
         end
         hold_v = ev;
      end

   initial begin
      logic [63:0]   f;
      logic [1023:0] bf;
      m_v = 0; m_s = 0; m_fl = 0; m_f = '0;
      s_v = 0; s_f = '0; s_d = {4'hA, 4'h5};
      b_v = 0; b_f = '0;
      for (int i = 0; i < 64; i++) m_d[i*6 +: 6] = 6'(i);
      for (int i = 0; i < 1024; i++) b_d[i*10 +: 10] = 10'(i);
      #12;
      chk("rst_valid", m_vo, 0);
      chk("rst_flag", m_fo, 0);
      chk("rst_data", m_do, 0);
      chk("rst_s_valid", s_vo, 0);
      chk("rst_b_valid", b_vo, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      f = '0; f[5] = 1; f[40] = 1;
      drive(1, 0, 0, f);
      idle(4);
      drive(1, 0, 0, '0);
      idle(4);
      for (int n = 0; n < 8; n++) begin
         f = '0;
         f[n*7] = 1;
         drive(1, 0, 0, f);
      end
      idle(4);
      for (int n = 0; n < 4; n++) drive(1, 0, 0, 64'd1 << (n * 9 + 1));
      repeat (4) drive(1, 1, 0, {$urandom, $urandom});
      for (int n = 0; n < 3; n++) drive(1, 0, 0, {$urandom, $urandom});
      idle(4);
      drive(1, 0, 0, 64'h0000_0100_0000_0000, 0);
      drive(1, 0, 0, 64'h0000_0000_0020_0000, 0);
      drive(1, 1, 1, {$urandom, $urandom}, 0);
      idle(1);
      drive(1, 0, 0, 64'h0000_0000_0400_0010);
      idle(5);
      drive(1, 0, 0, '1);
      drive(1, 0, 0, 64'd1);
      repeat (4) drive(1, 0, 0, {$urandom, $urandom});
      idle(4);
      drive(1, 0, 0, 64'd1 << 10);
      drive(1, 0, 0, 64'd1 << 62);
      drive(1, 0, 0, 64'd1 << 30);
      idle(1);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_valid", m_vo, 0);
      chk("arst_flag", m_fo, 0);
      chk("arst_data", m_do, 0);
`ifdef BTREE_PIPE_INDEX_EN
      chk("arst_index", m_io, 0);
`endif
      q.delete();
      hold_v = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b1;
      drive(1, 0, 0, 64'd1 << 33);
      idle(5);
      small_chk(2'b11, 1, 4'hA, 1);
      small_chk(2'b01, 1, 4'h5, 0);
      small_chk(2'b10, 1, 4'hA, 1);
      small_chk(2'b00, 0, 4'h0, 0);
      bf = '0; bf[3] = 1; bf[700] = 1;
      big_chk(bf, 1, 10'd700);
      bf = '0; bf[0] = 1;
      big_chk(bf, 1, 10'd0);
      big_chk('1, 1, 10'd1023);
      big_chk('0, 0, 10'd0);
      idle(2);
      chk("drain", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/btree_mux_pipe.md
Name: btree_mux_pipe

Overview:
- Parametrised, pipelined successor to the 64-way combinational flag/data binary-tree mux.
- Selects the highest-index input whose flag is set and returns its data, its flag and, optionally, its index.
- Registers the tree every REG_EVERY levels so large INPUT_COUNT closes timing.
- Sits between per-primitive hit/colour generators and the pixel output stage, and carries valid, stall and flush.

Parameters:
- INPUT_COUNT, 64: number of inputs; power of two, 2..1024.
- INPUT_WIDTH, 6: data width per input.
- REG_EVERY, 2: tree levels per pipeline stage, 1..LEVELS. LEVELS = log2(INPUT_COUNT) is a derived localparam.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- valid_in  in  1  input vector valid this cycle.
- stall  in  1  hold entire pipeline.
- flush  in  1  synchronous clear of all valid bits.
- flags_in  in  INPUT_COUNT  per-input hit flag.
- data_in  in  INPUT_COUNT*INPUT_WIDTH  flattened data; input i at [i*INPUT_WIDTH +: INPUT_WIDTH].
- valid_out  out  1  result valid.
- flag_out  out  1  any flag set in the associated input vector.
- data_out  out  INPUT_WIDTH  winning data.
- index_out  out  LEVELS  winning input index; present only with BTREE_PIPE_INDEX_EN.

Behaviour:
- Node rule, applied at every tree level to the pair (left = 2k, right = 2k+1):
  - right flag set -> forward right flag and data;
  - else left flag set -> forward left flag and data;
  - else flag 0 and data 0.
  - Net effect: the highest set index wins. When no flag is set, data_out = 0 and flag_out = 0.
- Stages: NSTAGES = ceil(LEVELS/REG_EVERY).
  - Registers sit after levels REG_EVERY, 2*REG_EVERY, ... The final level is always registered.
  - The final stage may hold fewer than REG_EVERY levels.
  - No register exists on the input side.
- Latency:
  - Exactly NSTAGES cycles from a valid_in sample to valid_out (64 inputs, REG_EVERY=2 -> 3 cycles).
  - Throughput is 1 vector/cycle when stall = 0.
- Valid:
  - A valid bit travels with each stage.
  - Data and flag registers of a stage load every non-stalled cycle, regardless of valid.
  - Outputs are meaningful only when valid_out = 1.
- stall = 1: every stage register, including valid bits, holds its value; inputs are ignored that cycle; outputs stay constant.
- flush = 1: all valid bits clear on the next edge; data and flag registers behave per stall/normal rules. flush has priority over stall for valid bits.
- Reset (rst_n low, asynchronous):
  - All stage registers clear, so valid_out = 0, flag_out = 0, data_out = 0, index_out = 0.
  - Deassertion mid-stream discards in-flight vectors; the first valid_out follows the first post-reset valid_in by NSTAGES cycles.
- Boundaries:
  - All flags set -> index INPUT_COUNT-1 wins.
  - Single flag at index 0 -> it wins through every level.
  - INPUT_COUNT = 2 -> one level, one stage.
  - REG_EVERY >= LEVELS -> one stage.

Optional Feature:
- BTREE_PIPE_INDEX_EN defined:
  - Each node also forwards an index: right wins -> {1, right_idx}; left wins -> {0, left_idx}; none -> 0.
  - The index is staged alongside data; index_out is LEVELS bits wide, has the same latency and resets to 0.
- Undefined: the index_out port and all index logic are absent; behaviour is otherwise identical.

Test Plan:
- INPUT_COUNT=64, REG_EVERY=2. Flags {5,40} set, data[i]=i, valid_in for 1 cycle -> after 3 cycles valid_out=1, flag_out=1, data_out=40, index_out=40.
- All flags 0, data[i]=i -> valid_out=1, flag_out=0, data_out=0, index_out=0 after 3 cycles.
- 8 back-to-back vectors, vector n with only flag n*7 set -> valid_out high 8 consecutive cycles with data_out=n*7 in order.
- stall high for 4 cycles mid-stream -> outputs frozen during the stall, no vector lost or duplicated, order preserved.
- flush pulsed with 3 vectors in flight, stall also high -> no valid_out for those vectors; a new vector after flush emerges 3 cycles later.
- rst_n low asynchronously with pipeline full -> outputs 0 immediately. Also run INPUT_COUNT=2 and INPUT_COUNT=1024 with REG_EVERY=3 -> latency 1 and 4 respectively, highest set index wins.
